game_timer_bcd: RTL

- Parametrised mm:ss game timer for the snake game.
- Counts up (elapsed play time) or down (time-limited round), from a preset value.
- Counts directly in BCD, so there is no binary-to-BCD conversion stage.
- Drives a 4-digit multiplexed 7-segment display (shared segment bus plus digit anodes) and flags round expiry to the game FSM.

---
 rtl/snake_timer_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/game_timer_bcd.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/snake_timer_pkg.sv
// Shared definitions for the snake game timer: FSM states, active-low
// 7-segment digit codes, display index width and a BCD minute helper.
package snake_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Number of bits needed to select one of the four display digits
  localparam int unsigned IDX_W = 2;

  // Segment order is {a,b,c,d,e,f,g}; a zero bit lights the segment
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Binary value of a two-digit BCD minute field (wide enough for 15*10+15)
  function automatic logic [7:0] min_value(logic [3:0] min_h, logic [3:0] min_l);
    return 8'(min_h) * 8'd10 + 8'(min_l);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code; non-BCD values blank the digit.
//   digit  : 4-bit BCD input
//   code_c : {a,b,c,d,e,f,g}, active-low, combinational
module seg7_decode
  import snake_timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] code_c
);

  always_comb begin
    code_c = SEG_BLANK;
    case (digit)
      4'd0:    code_c = SEG_0;
      4'd1:    code_c = SEG_1;
      4'd2:    code_c = SEG_2;
      4'd3:    code_c = SEG_3;
      4'd4:    code_c = SEG_4;
      4'd5:    code_c = SEG_5;
      4'd6:    code_c = SEG_6;
      4'd7:    code_c = SEG_7;
      4'd8:    code_c = SEG_8;
      4'd9:    code_c = SEG_9;
      default: code_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/game_timer_bcd.sv
// mm:ss game timer counting up or down directly in BCD, with a 4-digit
// multiplexed 7-segment display driver and round-expiry signalling.
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse, IDLE -> RUN, latches down into the direction
//   hold            : level, freezes counting in RUN
//   game_over       : stops a running timer (RUN -> STOP)
//   down            : 1 = countdown
//   load, load_bcd  : preset {min_h,min_l,sec_h,sec_l}, validated
//   time_bcd        : current time, registered
//   running         : state is RUN and hold is low
//   expired/wrapped/load_err : one-cycle event pulses, registered
//   seg, an         : active-low segment bus and digit selects, registered
module game_timer_bcd
  import snake_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  logic        game_over,
  input  logic        down,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        expired,
  output logic        wrapped,
  output logic        load_err,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_t            state;
  logic              dir;
  logic [TICK_W-1:0] presc;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;

  logic [15:0] up_bcd;
  logic [15:0] dn_bcd;
  logic        at_max;
  logic        load_ok;
  logic [3:0]  cur_digit;
  logic [6:0]  cur_code;

  // running follows hold immediately so the game FSM sees a freeze at once
  assign running = (state == RUN) && !hold;

  // Preset must be proper BCD, seconds below 60 and minutes within MAX_MIN
  always_comb begin
    load_ok = (load_bcd[15:12] <= 4'd9) && (load_bcd[11:8] <= 4'd9) &&
              (load_bcd[7:4]   <= 4'd5) && (load_bcd[3:0]  <= 4'd9) &&
              (min_value(load_bcd[15:12], load_bcd[11:8]) <= 8'(MAX_MIN));
  end

  assign at_max = (min_value(time_bcd[15:12], time_bcd[11:8]) == 8'(MAX_MIN)) &&
                  (time_bcd[7:0] == 8'h59);

  // Up-count carry chain; MAX_MIN:59 wraps to 00:00
  always_comb begin
    up_bcd = time_bcd;
    if (at_max) begin
      up_bcd = 16'h0000;
    end else if (time_bcd[3:0] != 4'd9) begin
      up_bcd[3:0] = time_bcd[3:0] + 4'd1;
    end else begin
      up_bcd[3:0] = 4'd0;
      if (time_bcd[7:4] != 4'd5) begin
        up_bcd[7:4] = time_bcd[7:4] + 4'd1;
      end else begin
        up_bcd[7:4] = 4'd0;
        if (time_bcd[11:8] != 4'd9) begin
          up_bcd[11:8] = time_bcd[11:8] + 4'd1;
        end else begin
          up_bcd[11:8]  = 4'd0;
          up_bcd[15:12] = time_bcd[15:12] + 4'd1;
        end
      end
    end
  end

  // Down-count borrow chain; 00:00 saturates so no underflow can occur
  always_comb begin
    dn_bcd = time_bcd;
    if (time_bcd == 16'h0000) begin
      dn_bcd = 16'h0000;
    end else if (time_bcd[3:0] != 4'd0) begin
      dn_bcd[3:0] = time_bcd[3:0] - 4'd1;
    end else begin
      dn_bcd[3:0] = 4'd9;
      if (time_bcd[7:4] != 4'd0) begin
        dn_bcd[7:4] = time_bcd[7:4] - 4'd1;
      end else begin
        dn_bcd[7:4] = 4'd5;
        if (time_bcd[11:8] != 4'd0) begin
          dn_bcd[11:8] = time_bcd[11:8] - 4'd1;
        end else begin
          dn_bcd[11:8]  = 4'd9;
          dn_bcd[15:12] = time_bcd[15:12] - 4'd1;
        end
      end
    end
  end

  assign cur_digit = time_bcd[{idx, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .digit  (cur_digit),
    .code_c (cur_code)
  );

  // Timer FSM, prescaler, BCD time register and display scan
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir      <= 1'b0;
      presc    <= '0;
      time_bcd <= 16'h0000;
      expired  <= 1'b0;
      wrapped  <= 1'b0;
      load_err <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 4'b1110;
      seg      <= SEG_0;
    end else begin
      expired  <= 1'b0;
      wrapped  <= 1'b0;
      load_err <= 1'b0;

      // Display scan runs in every state; seg/an lag idx by one cycle
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      seg <= cur_code;
      an  <= 4'(~(4'b0001 << idx));

      // A rejected load consumes the cycle: only load_err reacts
      if (load) begin
        if (load_ok) begin
          state    <= IDLE;
          time_bcd <= load_bcd;
          presc    <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              dir   <= down;
            end
          end
          RUN: begin
            if (game_over) begin
              state <= STOP;
            end else if (!hold) begin
              if (presc == TICK_LAST) begin
                presc <= '0;
                if (dir) begin
                  time_bcd <= dn_bcd;
                  if (dn_bcd == 16'h0000) begin
                    state   <= STOP;
                    expired <= 1'b1;
                  end
                end else begin
                  time_bcd <= up_bcd;
                  wrapped  <= at_max;
                end
              end else begin
                presc <= presc + TICK_W'(1);
              end
            end
          end
          STOP: begin
            state <= STOP;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
